ir_calc_sequencer: RTL and testbench

Key-entry controller for the IR calculator datapath. Consumes key strobes from the IR decoder (`okBit` plus an 8-bit key code) and assembles two decimal operands of 0–99. It selects add or subtract, fires the ALU with a one-cycle go pulse, and latches the ALU result after a fixed latency for the display decoders. It sits between the IR decoder and the ALU, replacing direct decoder-to-ALU wiring.

---
 rtl/ir_calc_sequencer.sv | 157 +++++++++++++++
 tb/tb_ir_calc_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_calc_sequencer.sv
// Key-entry sequencer: builds two 0-99 operands from IR key strobes, fires the ALU, latches its result.
// Keys act at the detecting edge; the result latches ALU_LAT edges after aluGo; no backpressure.
module ir_calc_sequencer #(
    parameter int unsigned ALU_LAT = 2,
    parameter logic [7:0]  KEY_ADD = 8'h1A,
    parameter logic [7:0]  KEY_SUB = 8'h1E,
    parameter logic [7:0]  KEY_EQ  = 8'h12,
    parameter logic [7:0]  KEY_CLR = 8'h0F
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       okBit,
    input  logic [7:0] dataDec,
    input  logic [7:0] aluRes,
    input  logic       aluSign,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       opSel,
    output logic       aluGo,
    output logic [7:0] result,
    output logic       resSign,
    output logic       resValid,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        WAIT    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    state_t     state_q;
    logic       ok_prev_q;
    logic [1:0] cnt_a_q;
    logic [1:0] cnt_b_q;
    logic [3:0] wait_cnt_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] result_q;
    logic       op_sel_q;
    logic       alu_go_q;
    logic       res_sign_q;
    logic       res_valid_q;

    logic       key_evt;
    logic       is_digit;
    logic       is_op;
    logic       is_sub;
    logic       is_eq;
    logic       is_clr;
    logic [7:0] digit_val;
    logic [7:0] a_d;
    logic [7:0] b_d;

    // Digit codes take precedence so a colliding key parameter can never hijack a digit.
    always_comb begin
        key_evt   = okBit & ~ok_prev_q;
        is_digit  = (dataDec < 8'd10);
        is_sub    = ~is_digit & (dataDec == KEY_SUB);
        is_op     = ~is_digit & ((dataDec == KEY_ADD) | (dataDec == KEY_SUB));
        is_eq     = ~is_digit & ~is_op & (dataDec == KEY_EQ);
        is_clr    = ~is_digit & ~is_op & ~is_eq & (dataDec == KEY_CLR);
        digit_val = {4'd0, dataDec[3:0]};
        a_d       = (a_q * 8'd10) + digit_val;
        b_d       = (b_q * 8'd10) + digit_val;
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q     <= ENTER_A;
            ok_prev_q   <= 1'b0;
            cnt_a_q     <= 2'd0;
            cnt_b_q     <= 2'd0;
            wait_cnt_q  <= 4'd0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            result_q    <= 8'd0;
            op_sel_q    <= 1'b0;
            alu_go_q    <= 1'b0;
            res_sign_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            ok_prev_q <= okBit;
            alu_go_q  <= 1'b0;
            if (key_evt && is_clr) begin
                state_q     <= ENTER_A;
                cnt_a_q     <= 2'd0;
                cnt_b_q     <= 2'd0;
                wait_cnt_q  <= 4'd0;
                a_q         <= 8'd0;
                b_q         <= 8'd0;
                result_q    <= 8'd0;
                op_sel_q    <= 1'b0;
                res_sign_q  <= 1'b0;
                res_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ENTER_A: begin
                        if (key_evt && is_digit && (cnt_a_q < 2'd2)) begin
                            a_q     <= a_d;
                            cnt_a_q <= cnt_a_q + 2'd1;
                        end else if (key_evt && is_op) begin
                            op_sel_q <= is_sub;
                            state_q  <= ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (key_evt && is_digit && (cnt_b_q < 2'd2)) begin
                            b_q     <= b_d;
                            cnt_b_q <= cnt_b_q + 2'd1;
                        end else if (key_evt && is_op) begin
                            op_sel_q <= is_sub;
                        end else if (key_evt && is_eq) begin
                            alu_go_q   <= 1'b1;
                            wait_cnt_q <= 4'(ALU_LAT);
                            state_q    <= WAIT;
                        end
                    end
                    WAIT: begin
                        // Count reaches 1 on the ALU_LAT-th edge after the go edge.
                        if (wait_cnt_q <= 4'd1) begin
                            result_q    <= aluRes;
                            res_sign_q  <= aluSign;
                            res_valid_q <= 1'b1;
                            wait_cnt_q  <= 4'd0;
                            state_q     <= SHOW;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 4'd1;
                        end
                    end
                    SHOW: begin
                        if (key_evt && is_digit) begin
                            a_q         <= digit_val;
                            cnt_a_q     <= 2'd1;
                            b_q         <= 8'd0;
                            cnt_b_q     <= 2'd0;
                            res_valid_q <= 1'b0;
                            state_q     <= ENTER_A;
                        end
                    end
                    default: state_q <= ENTER_A;
                endcase
            end
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign opSel    = op_sel_q;
    assign aluGo    = alu_go_q;
    assign result   = result_q;
    assign resSign  = res_sign_q;
    assign resValid = res_valid_q;
    assign state    = state_q;

endmodule

// File: tb/tb_ir_calc_sequencer.sv
// Directed bench for ir_calc_sequencer: key-sequence table plus hand-timed corner sequences.
module tb_ir_calc_sequencer;

    localparam logic [7:0] K_ADD = 8'h1A;
    localparam logic [7:0] K_SUB = 8'h1E;
    localparam logic [7:0] K_EQ  = 8'h12;
    localparam logic [7:0] K_CLR = 8'h0F;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       okBit = 1'b0;
    logic [7:0] dataDec = 8'h00;
    logic [7:0] aluRes;
    logic       aluSign;
    logic [7:0] A, B, result;
    logic       opSel, aluGo, resSign, resValid;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;
    int gos = 0;
    int alu_age = 0;

    ir_calc_sequencer #(.ALU_LAT(2)) dut (
        .CLOCK_50(clk), .RESET(rst), .okBit(okBit), .dataDec(dataDec),
        .aluRes(aluRes), .aluSign(aluSign),
        .A(A), .B(B), .opSel(opSel), .aluGo(aluGo),
        .result(result), .resSign(resSign), .resValid(resValid), .state(state)
    );

    always #5 clk = ~clk;

    // ALU model: answer is only present during the cycle before the second edge after aluGo.
    always @(posedge clk) begin
        if (aluGo) alu_age <= 1;
        else if (alu_age != 0 && alu_age < 10) alu_age <= alu_age + 1;
        else alu_age <= 0;
        if (aluGo) gos <= gos + 1;
    end

    always_comb begin
        aluRes  = 8'hEE;
        aluSign = 1'b1;
        if (alu_age == 1) begin
            if (!opSel) begin
                aluRes  = A + B;
                aluSign = 1'b0;
            end else if (A >= B) begin
                aluRes  = A - B;
                aluSign = 1'b0;
            end else begin
                aluRes  = B - A;
                aluSign = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [7:0] code);
        @(negedge clk);
        dataDec = code;
        okBit   = 1'b1;
        @(negedge clk);
        okBit   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        okBit = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        string       name;
        logic [63:0] keys;
        int          n;
        logic [7:0]  a, b;
        logic        op;
        logic [7:0]  res;
        logic        sgn, vld;
        logic [1:0]  st;
        int          ngo;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [63:0] keys, input int n,
                                input logic [7:0] a, input logic [7:0] b, input logic op,
                                input logic [7:0] res, input logic sgn, input logic vld,
                                input logic [1:0] st, input int ngo);
        vec_t v;
        v.name = name; v.keys = keys; v.n = n; v.a = a; v.b = b; v.op = op;
        v.res = res; v.sgn = sgn; v.vld = vld; v.st = st; v.ngo = ngo;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        vec_t       v;
        logic [7:0] k;
        int         g0;

        vecs[0] = mk("add42_17", {8'h04, 8'h02, K_ADD, 8'h01, 8'h07, K_EQ, 8'h00, 8'h00}, 6,
                     8'd42, 8'd17, 1'b0, 8'd59, 1'b0, 1'b1, 2'd3, 1);
        vecs[1] = mk("sub99_20", {8'h09, 8'h09, 8'h05, K_SUB, 8'h02, 8'h00, K_EQ, 8'h00}, 7,
                     8'd99, 8'd20, 1'b1, 8'd79, 1'b0, 1'b1, 2'd3, 1);
        vecs[2] = mk("sub5_20", {8'h05, K_SUB, 8'h02, 8'h00, K_EQ, 8'h00, 8'h00, 8'h00}, 5,
                     8'd5, 8'd20, 1'b1, 8'd15, 1'b1, 1'b1, 2'd3, 1);
        vecs[3] = mk("zero_ops", {K_ADD, K_EQ, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2,
                     8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 2'd3, 1);
        vecs[4] = mk("op_overwrite", {8'h03, K_ADD, K_SUB, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00}, 4,
                     8'd3, 8'd6, 1'b1, 8'd0, 1'b0, 1'b0, 2'd1, 0);
        vecs[5] = mk("eq_in_enter_a", {8'h01, 8'h02, K_EQ, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3,
                     8'd12, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 0);
        vecs[6] = mk("clr_in_b", {8'h04, 8'h02, K_ADD, 8'h01, K_CLR, 8'h00, 8'h00, 8'h00}, 5,
                     8'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 0);
        vecs[7] = mk("bad_code", {8'h44, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2,
                     8'd8, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 2'd0, 0);

        idle(2);
        chk("rst_A", A, 0);           chk("rst_B", B, 0);
        chk("rst_opSel", opSel, 0);   chk("rst_aluGo", aluGo, 0);
        chk("rst_result", result, 0); chk("rst_resSign", resSign, 0);
        chk("rst_resValid", resValid, 0); chk("rst_state", state, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            do_reset();
            g0 = gos;
            for (int j = 0; j < v.n; j++) begin
                k = v.keys[63-8*j -: 8];
                press(k);
            end
            idle(6);
            chk({v.name, "_A"}, A, v.a);
            chk({v.name, "_B"}, B, v.b);
            chk({v.name, "_opSel"}, opSel, v.op);
            chk({v.name, "_result"}, result, v.res);
            chk({v.name, "_resSign"}, resSign, v.sgn);
            chk({v.name, "_resValid"}, resValid, v.vld);
            chk({v.name, "_state"}, state, v.st);
            chk({v.name, "_gos"}, gos - g0, v.ngo);
        end

        // Exact go/latch timing.
        do_reset();
        press(8'h04); press(8'h02); press(K_ADD); press(8'h01); press(8'h07);
        @(negedge clk); dataDec = K_EQ; okBit = 1'b1;
        @(posedge clk); #1;
        chk("t_e0_aluGo", aluGo, 1); chk("t_e0_state", state, 2); chk("t_e0_vld", resValid, 0);
        @(negedge clk); okBit = 1'b0;
        @(posedge clk); #1;
        chk("t_e1_aluGo", aluGo, 0); chk("t_e1_vld", resValid, 0);
        @(posedge clk); #1;
        chk("t_e2_vld", resValid, 1); chk("t_e2_result", result, 59); chk("t_e2_state", state, 3);

        // New calculation started from SHOW.
        press(8'h07);
        idle(1);
        chk("show_A", A, 7); chk("show_B", B, 0); chk("show_vld", resValid, 0); chk("show_state", state, 0);
        press(K_ADD); press(8'h03); press(K_EQ);
        idle(5);
        chk("show2_A", A, 7); chk("show2_B", B, 3); chk("show2_result", result, 10);
        chk("show2_vld", resValid, 1); chk("show2_state", state, 3);

        // Long okBit hold gives one event; unknown code has no effect.
        do_reset();
        @(negedge clk); dataDec = 8'h03; okBit = 1'b1;
        idle(50);
        okBit = 1'b0;
        idle(1);
        chk("hold_A", A, 3);
        press(8'h44);
        idle(2);
        chk("hold_bad_A", A, 3); chk("hold_bad_state", state, 0);
        press(8'h05);
        idle(1);
        chk("hold_second_digit", A, 35);

        // CLR lands on the latch edge and must win.
        do_reset();
        press(8'h01); press(K_ADD); press(8'h02);
        @(negedge clk); dataDec = K_EQ; okBit = 1'b1;
        @(posedge clk);
        @(negedge clk); okBit = 1'b0;
        @(posedge clk);
        @(negedge clk); dataDec = K_CLR; okBit = 1'b1;
        @(posedge clk); #1;
        chk("clrw_state", state, 0); chk("clrw_vld", resValid, 0);
        chk("clrw_A", A, 0); chk("clrw_B", B, 0); chk("clrw_result", result, 0);
        @(negedge clk); okBit = 1'b0;
        idle(4);
        chk("clrw_late_vld", resValid, 0); chk("clrw_late_state", state, 0);

        // RESET in ENTER_B with okBit held through the reset release.
        do_reset();
        press(8'h01); press(8'h02); press(K_ADD); press(8'h03);
        idle(1);
        chk("pre_rst_A", A, 12);
        @(negedge clk); rst = 1'b1; dataDec = 8'h05; okBit = 1'b1;
        @(negedge clk);
        chk("midrst_A", A, 0); chk("midrst_B", B, 0); chk("midrst_state", state, 0);
        chk("midrst_opSel", opSel, 0); chk("midrst_vld", resValid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_event_A", A, 5);
        okBit = 1'b0;
        idle(2);
        chk("post_rst_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
